// File: rtl/mmio_timer_slave_pkg.sv
// Shared constants and types for the memory-mapped timer peripheral.
package mmio_timer_slave_pkg;

    localparam int unsigned COUNT_WIDTH = 32;

    // Word offsets decoded from address[4:2]
    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_PRESCALE = 3'd1;
    localparam logic [2:0] TMR_COMPARE  = 3'd2;
    localparam logic [2:0] TMR_COUNT    = 3'd3;
    localparam logic [2:0] TMR_STATUS   = 3'd4;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE      = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;

    // STATUS bit positions
    localparam int unsigned STATUS_MATCH = 0;

    localparam logic [COUNT_WIDTH-1:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_EXPIRED = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: emits one tick every (limit + 1) cycles while run is high.
module timer_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] limit,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pre_cnt;

    // Tick fires on the cycle the divider reaches its terminal value
    assign tick = run && (pre_cnt == limit);

    // Divider counter; clear wins so a restart always begins a full period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (run) begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_timer_slave.sv
// Memory-mapped prescaled timer with compare match, one-shot/auto-reload and level irq.
module mmio_timer_slave
    import mmio_timer_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);

    tmr_state_e                state_q, state_d;
    logic                      auto_reload_q, auto_reload_d;
    logic                      irq_en_q, irq_en_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [COUNT_WIDTH-1:0]    compare_q, compare_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic                      match_q, match_d;

    logic [2:0] offset;
    logic       wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic       running, tick, hit, pre_clear;
    logic       unused_addr_bits;

    assign offset      = address[4:2];
    assign wr_ctrl     = we && (offset == TMR_CTRL);
    assign wr_prescale = we && (offset == TMR_PRESCALE);
    assign wr_compare  = we && (offset == TMR_COMPARE);
    assign wr_count    = we && (offset == TMR_COUNT);
    assign wr_status   = we && (offset == TMR_STATUS);

    assign unused_addr_bits = ^{address[31:5], address[1:0]};

    // CTRL.enable is exactly "the timer is running", so it is read from the state
    assign running = (state_q == ST_RUNNING);
    assign hit     = tick && (count_q == compare_q);

    // Restart from a stopped/expired timer or a new PRESCALE starts a fresh prescale period
    assign pre_clear = wr_prescale || (wr_ctrl && wd[CTRL_ENABLE] && !running);

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (running),
        .clear (pre_clear),
        .limit (prescale_q),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a CTRL write always overrides the hardware one-shot expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOPPED: begin
                if (wr_ctrl && wd[CTRL_ENABLE]) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (wr_ctrl) begin
                    state_d = wd[CTRL_ENABLE] ? ST_RUNNING : ST_STOPPED;
                end else if (hit && !auto_reload_q) begin
                    state_d = ST_EXPIRED;
                end
            end
            ST_EXPIRED: begin
                if (wr_ctrl) begin
                    state_d = wd[CTRL_ENABLE] ? ST_RUNNING : ST_STOPPED;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // Register file next values: CPU writes beat count updates, match set beats W1C
    always_comb begin
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        prescale_d    = prescale_q;
        compare_d     = compare_q;
        count_d       = count_q;
        match_d       = match_q;

        if (wr_ctrl) begin
            auto_reload_d = wd[CTRL_AUTO_RELOAD];
            irq_en_d      = wd[CTRL_IRQ_EN];
        end
        if (wr_prescale) begin
            prescale_d = wd[PRESCALE_WIDTH-1:0];
        end
        if (wr_compare) begin
            compare_d = COUNT_WIDTH'(wd);
        end

        if (wr_count) begin
            count_d = COUNT_WIDTH'(wd);
        end else if (hit) begin
            count_d = auto_reload_q ? '0 : count_q;
        end else if (tick) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end

        if (hit) begin
            match_d = 1'b1;
        end else if (wr_status && wd[STATUS_MATCH]) begin
            match_d = 1'b0;
        end
    end

    // Register file flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            prescale_q    <= '0;
            compare_q     <= COMPARE_RST;
            count_q       <= '0;
            match_q       <= 1'b0;
        end else begin
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            prescale_q    <= prescale_d;
            compare_q     <= compare_d;
            count_q       <= count_d;
            match_q       <= match_d;
        end
    end

    // Zero-latency read mux; the MEM stage samples rd in the same cycle as re
    always_comb begin
        rd = '0;
        if (re) begin
            case (offset)
                TMR_CTRL:     rd = DATA_WIDTH'({irq_en_q, auto_reload_q, running});
                TMR_PRESCALE: rd = DATA_WIDTH'(prescale_q);
                TMR_COMPARE:  rd = DATA_WIDTH'(compare_q);
                TMR_COUNT:    rd = DATA_WIDTH'(count_q);
                TMR_STATUS:   rd = DATA_WIDTH'(match_q);
                default:      rd = '0;
            endcase
        end
    end

    // Level interrupt
    assign irq = match_q & irq_en_q;

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Randomized and directed bench for mmio_timer_slave with a register-level reference model.
module tb_mmio_timer_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wd;
    logic [31:0] address;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mmio_timer_slave #(
        .DATA_WIDTH     (32),
        .PRESCALE_WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wd      (wd),
        .address (address),
        .we      (we),
        .re      (re),
        .rd      (rd),
        .irq     (irq)
    );

    // Reference model: architectural register values plus a prescale phase counter
    bit          m_en, m_ar, m_ie, m_match;
    logic [15:0] m_pre, m_pc;
    logic [31:0] m_cmp, m_cnt;
    logic [2:0]  m_off;
    bit          m_tick, m_hit;

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0:    return {29'd0, m_ie, m_ar, m_en};
            3'd1:    return {16'd0, m_pre};
            3'd2:    return m_cmp;
            3'd3:    return m_cnt;
            3'd4:    return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
            m_pre = 16'd0; m_pc = 16'd0;
            m_cmp = 32'hFFFF_FFFF; m_cnt = 32'd0;
        end else begin
            m_off  = address[4:2];
            m_tick = m_en && (m_pc == m_pre);
            m_hit  = m_tick && (m_cnt == m_cmp);
            // prescale phase
            if ((we && m_off == 3'd1) || (we && m_off == 3'd0 && wd[0] && !m_en)) m_pc = 16'd0;
            else if (m_tick) m_pc = 16'd0;
            else if (m_en) m_pc = m_pc + 16'd1;
            // counter
            if (we && m_off == 3'd3) m_cnt = wd;
            else if (m_hit) m_cnt = m_ar ? 32'd0 : m_cnt;
            else if (m_tick) m_cnt = m_cnt + 32'd1;
            // status
            if (m_hit) m_match = 1;
            else if (we && m_off == 3'd4 && wd[0]) m_match = 0;
            // enable
            if (we && m_off == 3'd0) m_en = wd[0];
            else if (m_hit && !m_ar) m_en = 0;
            // remaining registers
            if (we && m_off == 3'd0) begin m_ar = wd[1]; m_ie = wd[2]; end
            if (we && m_off == 3'd1) m_pre = wd[15:0];
            if (we && m_off == 3'd2) m_cmp = wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every cycle: compare outputs against the model, well away from the rising edge
    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            check("model_rd", rd, re ? m_read(address[4:2]) : 32'd0);
            check("model_irq", {31'd0, irq}, {31'd0, m_match && m_ie});
        end
    end

    task automatic cyc();
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        we = 1'b1;
        re = 1'b0;
        address = {27'd0, off, 2'b00};
        wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rdchk(input logic [2:0] off, input logic [31:0] exp, input string name);
        re = 1'b1;
        address = {27'd0, off, 2'b00};
        #1;
        check(name, rd, exp);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; wd = 32'd0; address = 32'd0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        rst = 1'b0;

        // reset values
        rdchk(3'd0, 32'd0, "rst_ctrl");        cyc();
        rdchk(3'd1, 32'd0, "rst_prescale");    cyc();
        rdchk(3'd2, 32'hFFFF_FFFF, "rst_compare"); cyc();
        rdchk(3'd3, 32'd0, "rst_count");       cyc();
        rdchk(3'd4, 32'd0, "rst_status");
        check("rst_irq", {31'd0, irq}, 32'd0);
        cyc();

        // one-shot, prescale 0, compare 3
        wr(3'd1, 32'd0); wr(3'd2, 32'd3); wr(3'd0, 32'd5);
        rdchk(3'd3, 32'd0, "t2_cnt0"); cyc();
        rdchk(3'd3, 32'd1, "t2_cnt1"); cyc();
        rdchk(3'd3, 32'd2, "t2_cnt2"); cyc();
        rdchk(3'd3, 32'd3, "t2_cnt3");
        check("t2_irq_low", {31'd0, irq}, 32'd0);
        cyc();
        rdchk(3'd4, 32'd1, "t2_match");
        check("t2_irq", {31'd0, irq}, 32'd1);
        cyc();
        rdchk(3'd0, 32'd4, "t2_ctrl");  cyc();
        rdchk(3'd3, 32'd3, "t2_hold");  cyc();

        // auto-reload, prescale 2, compare 1 -> 6 cycle period
        wr(3'd4, 32'd1);
        #1 check("t3_clr_irq", {31'd0, irq}, 32'd0);
        wr(3'd1, 32'd2); wr(3'd2, 32'd1); wr(3'd3, 32'd0); wr(3'd0, 32'd7);
        repeat (5) cyc();
        rdchk(3'd3, 32'd1, "t3_cnt1");
        rdchk(3'd4, 32'd0, "t3_nomatch");
        cyc();
        rdchk(3'd4, 32'd1, "t3_match");
        rdchk(3'd3, 32'd0, "t3_reload");
        wr(3'd4, 32'd1);
        #1 check("t3_w1c_irq", {31'd0, irq}, 32'd0);
        repeat (4) cyc();
        wr(3'd4, 32'd1);
        rdchk(3'd4, 32'd1, "t3_w1c_race");
        wr(3'd0, 32'd0);

        // CPU COUNT write beats a tick increment
        wr(3'd4, 32'd1); wr(3'd1, 32'd0); wr(3'd2, 32'd100); wr(3'd3, 32'd0); wr(3'd0, 32'd1);
        cyc();
        wr(3'd3, 32'h10);
        rdchk(3'd3, 32'h10, "t4_cpu_wins"); cyc();
        rdchk(3'd3, 32'h11, "t4_next");
        wr(3'd0, 32'd0);

        // wrap past all-ones without a match
        wr(3'd3, 32'hFFFF_FFFF); wr(3'd2, 32'd5); wr(3'd0, 32'd1);
        cyc();
        rdchk(3'd3, 32'd0, "t5_wrap");
        rdchk(3'd4, 32'd0, "t5_nomatch");
        repeat (5) cyc();
        rdchk(3'd3, 32'd5, "t5_cnt5");
        cyc();
        rdchk(3'd4, 32'd1, "t5_match");
        rdchk(3'd0, 32'd0, "t5_ctrl");

        // asynchronous reset while running mid-prescale
        wr(3'd4, 32'd1); wr(3'd1, 32'd3); wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd0, 32'd7);
        repeat (4) cyc();
        #1 check("t6_irq", {31'd0, irq}, 32'd1);
        cyc();
        re = 1'b1;
        address = 32'h8;
        #1 rst = 1'b1;
        #1;
        check("t6_rst_cmp", rd, 32'hFFFF_FFFF);
        check("t6_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (6) cyc();
        rdchk(3'd3, 32'd0, "t6_cnt");
        rdchk(3'd4, 32'd0, "t6_status");
        rdchk(3'd0, 32'd0, "t6_ctrl");
        cyc();

        // randomized register traffic
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] off;
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            off = 3'($urandom_range(0, 7));
            address = $urandom;
            address[4:2] = off;
            we = ($urandom_range(0, 7) == 0);
            re = 1'($urandom_range(0, 1));
            case (off)
                3'd0: begin wd = $urandom; wd[0] = ($urandom_range(0, 9) < 7); end
                3'd1: wd = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 3);
                3'd2: wd = $urandom_range(0, 12);
                3'd3: wd = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                      : $urandom_range(0, 12);
                default: wd = $urandom;
            endcase
        end
        @(negedge clk);
        rst = 1'b0; we = 1'b0; re = 1'b0;
        cyc();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
